// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imem_loader_pkg                                                   |
// | Shared definitions for the instruction-memory loader: default data width,  |
// | loader state encoding and the per-state status-flag decode.                |
// | Optional feature macro used by the loader: IMEM_LOADER_CSUM_EN             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

    localparam int XLEN_WIDTH = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic core_hold;
        logic done;
        logic error;
    } status_t;

    // Status flags are a pure function of the state being entered; the FSM
    // registers them together with the state so every flag is a flop output.
    function automatic status_t status_of(loader_state_t s);
        status_t st;
        st = '0;
        case (s)
            ST_LEN, ST_DATA, ST_CSUM: begin
                st.in_ready  = 1'b1;
                st.busy      = 1'b1;
                st.core_hold = 1'b1;
            end
            ST_DONE: st.done = 1'b1;
            ST_ERR: begin
                st.error     = 1'b1;
                st.core_hold = 1'b1;
            end
            default: st.core_hold = 1'b1;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imem_loader_pack                                                  |
// | Little-endian byte-to-word assembler. Collects three bytes in a shift      |
// | register; word_valid is raised combinationally in the cycle the fourth     |
// | byte is presented, with word = {byte3, byte2, byte1, byte0}.               |
// | Ports: clk, rst (async active-low), clear (restart at byte 0), byte_en,    |
// |        byte_in[7:0] -> word_valid, word[31:0]                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader_pack
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] partial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            partial <= '0;
        end else if (clear) begin
            idx     <= '0;
            partial <= '0;
        end else if (byte_en) begin
            idx     <= idx + 2'd1;
            // Newest byte enters at the top so the oldest ends up in [7:0].
            partial <= {byte_in, partial[23:8]};
        end
    end

    assign word_valid = byte_en && (idx == 2'(WORD_BYTES - 1));
    assign word       = {byte_in, partial};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imem_loader                                                       |
// | Loads a program image from a host byte stream into instruction memory and  |
// | holds the core until the image is completely written.                      |
// | Stream: 4-byte LE word count N, then N LE words (then a 4-byte LE sum when |
// | IMEM_LOADER_CSUM_EN is defined).                                           |
// | Ports: clk, rst (async active-low), start, in_data[7:0], in_valid ->       |
// |        in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, core_hold, busy,     |
// |        done, error                                                         |
// | Optional feature macro: IMEM_LOADER_CSUM_EN (checksum stage after data)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              XLEN      = XLEN_WIDTH,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            mem_wr_en,
    output logic [XLEN-1:0] mem_wr_addr,
    output logic [XLEN-1:0] mem_wr_data,
    output logic            core_hold,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int KW = $clog2(DEPTH);

    loader_state_t state;
    status_t       status;
    logic [KW-1:0] k;
    logic [KW:0]   n_words;

    logic          load_start;
    logic          byte_en;
    logic          word_valid;
    logic [31:0]   word;
    logic          last_word;

`ifdef IMEM_LOADER_CSUM_EN
    logic [XLEN-1:0] sum;
`endif

    assign load_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign byte_en    = in_valid && status.in_ready;
    assign last_word  = ({1'b0, k} == (n_words - 1'b1));

    imem_loader_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            status      <= status_of(ST_IDLE);
            k           <= '0;
            n_words     <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            sum         <= '0;
`endif
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state   <= ST_LEN;
                        status  <= status_of(ST_LEN);
                        k       <= '0;
                        n_words <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        sum     <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (word_valid) begin
                        // Range check up front guarantees k never wraps in DATA.
                        if (word == 32'd0 || word > 32'(DEPTH)) begin
                            state  <= ST_ERR;
                            status <= status_of(ST_ERR);
                        end else begin
                            state   <= ST_DATA;
                            status  <= status_of(ST_DATA);
                            n_words <= word[KW:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= BASE_ADDR + XLEN'({k, 2'b00});
                        mem_wr_data <= XLEN'(word);
                        k           <= k + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                        sum         <= sum + XLEN'(word);
`endif
                        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state  <= ST_CSUM;
                            status <= status_of(ST_CSUM);
`else
                            state  <= ST_DONE;
                            status <= status_of(ST_DONE);
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (word_valid) begin
                        if (sum == XLEN'(word)) begin
                            state  <= ST_DONE;
                            status <= status_of(ST_DONE);
                        end else begin
                            state  <= ST_ERR;
                            status <= status_of(ST_ERR);
                        end
                    end
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    status <= status_of(ST_IDLE);
                end
            endcase
        end
    end

    assign in_ready  = status.in_ready;
    assign busy      = status.busy;
    assign core_hold = status.core_hold;
    assign done      = status.done;
    assign error     = status.error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for imem_loader: randomized byte streams, a reference model that
// derives expected ROM writes and final status from the stream, and a
// scoreboard monitor that checks every write strobe (address, data, cycle).
module tb_imem_loader;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .core_hold   (core_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_wr_addr, mem_wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", mem_wr_addr, e.addr);
                check("wr_data", mem_wr_data, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push_le(inout logic [7:0] q[$], input logic [31:0] v);
        for (int b = 0; b < 4; b++) q.push_back(v[8*b +: 8]);
    endtask

    // One complete load. abort_at >= 0 stops streaming after that byte index
    // and skips the final status checks (caller takes over).
    task automatic run_load(input logic [31:0] n_hdr, input logic [31:0] words[$],
                            input int gap_max, input bit alt_gap, input int start_at,
                            input logic [31:0] csum_delta, input int abort_at);
        logic [7:0]  bytes[$];
        logic [31:0] s;
        bit          hdr_ok;
        bit          ok;
        int          tmo;
        int          g;
        hdr_ok = (n_hdr != 0) && (n_hdr <= DEPTH);
        ok     = hdr_ok;
        s      = 32'd0;
        push_le(bytes, n_hdr);
        if (hdr_ok) begin
            for (int k = 0; k < int'(n_hdr); k++) begin
                push_le(bytes, words[k]);
                s = s + words[k];
            end
`ifdef IMEM_LOADER_CSUM_EN
            push_le(bytes, s + csum_delta);
            ok = (csum_delta == 32'd0);
`endif
        end

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_core_hold", {31'd0, core_hold}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done_clr", {30'd0, done, error}, 32'd0);

        for (int i = 0; i < bytes.size(); i++) begin
            g = alt_gap ? 1 : int'($urandom_range(0, gap_max));
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            start    = (i == start_at);
            tmo = 0;
            while (in_ready !== 1'b1 && tmo < 50) begin
                @(negedge clk);
                start = 1'b0;
                tmo++;
            end
            if (tmo >= 50) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_accept_timeout: got in_ready 0 for byte %0d expected 1", i);
                break;
            end
            if (hdr_ok && i >= 4 && i < 4 + 4 * int'(n_hdr) && ((i - 4) % 4) == 3) begin
                exp_t e;
                e.addr = BASE + 32'(4 * ((i - 4) / 4));
                e.data = words[(i - 4) / 4];
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk);
            start = 1'b0;
            if (i == abort_at) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_writes", 32'(sb.size()), 32'd0);
        check("done", {31'd0, done}, {31'd0, ok});
        check("error", {31'd0, error}, {31'd0, !ok});
        check("core_hold", {31'd0, core_hold}, {31'd0, !ok});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("in_ready_end", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic rand_words(inout logic [31:0] w[$], input int n);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back($urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w[$];

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_flags", {27'd0, in_ready, busy, done, error, mem_wr_en}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_flags", {27'd0, in_ready, busy, done, error, core_hold}, 32'd1);

        // Two-word directed image
        w.delete(); w.push_back(32'h0000_0013); w.push_back(32'h0010_0093);
        run_load(32'd2, w, 0, 1'b0, -1, 32'd0, -1);

        // Bad headers: zero and one past capacity
        w.delete();
        run_load(32'd0, w, 0, 1'b0, -1, 32'd0, -1);
        run_load(32'(DEPTH + 1), w, 0, 1'b0, -1, 32'd0, -1);

        // in_valid toggling every other cycle
        rand_words(w, 3);
        run_load(32'd3, w, 0, 1'b1, -1, 32'd0, -1);

        // Reset in the middle of word 1 of a 4-word image
        rand_words(w, 4);
        run_load(32'd4, w, 0, 1'b0, -1, 32'd0, 9);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_flags", {28'd0, in_ready, busy, done, error}, 32'd0);
        check("abort_core_hold", {31'd0, core_hold}, 32'd1);
        check("abort_pending", 32'(sb.size()), 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        rand_words(w, 4);
        run_load(32'd4, w, 1, 1'b0, -1, 32'd0, -1);

        // start pulse in the middle of the data phase is ignored
        rand_words(w, 3);
        run_load(32'd3, w, 1, 1'b0, 9, 32'd0, -1);

        // Random images
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 8));
            rand_words(w, n);
            run_load(32'(n), w, 2, 1'b0, -1, 32'd0, -1);
        end

        // Full-capacity image: last address and no counter wrap
        rand_words(w, DEPTH);
        run_load(32'(DEPTH), w, 0, 1'b0, -1, 32'd0, -1);

`ifdef IMEM_LOADER_CSUM_EN
        w.delete(); w.push_back(32'h1); w.push_back(32'h2);
        run_load(32'd2, w, 0, 1'b0, -1, 32'd0, -1);
        run_load(32'd2, w, 0, 1'b0, -1, 32'd1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
